// File: rtl/pms_top_pkg.sv
// Shared PMS top-level types and constants for the external interrupt path.
package pms_top_pkg;

  localparam int unsigned NUM_EXT_INTERRUPTS = 222;
  localparam int unsigned NUM_EXT_IRQ_PMS    = NUM_EXT_INTERRUPTS;

  typedef enum logic {
    IRQ_LEVEL = 1'b0,
    IRQ_EDGE  = 1'b1
  } irq_mode_e;

  typedef logic [$clog2(NUM_EXT_INTERRUPTS)-1:0] ext_irq_id_t;

  // Keeps ID fields at least one bit wide for single-line builds.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pms_irq_prio_arb.sv
// Combinational interrupt arbiter: fixed lowest-index priority, or round-robin
// from a priority pointer when PMS_EXT_IRQ_RR_EN is defined.
module pms_irq_prio_arb
  import pms_top_pkg::*;
#(
  parameter int unsigned NUM  = NUM_EXT_IRQ_PMS,
  parameter int unsigned ID_W = id_width(NUM)
) (
  input  logic [NUM-1:0]  eligible_i,
`ifdef PMS_EXT_IRQ_RR_EN
  input  logic [ID_W-1:0] ptr_i,
`endif
  output logic [ID_W-1:0] win_id_o,
  output logic            found_o
);

`ifdef PMS_EXT_IRQ_RR_EN
  logic [ID_W-1:0] hi_id, lo_id;
  logic            hi_found, lo_found;
  logic [31:0]     ptr_ext;

  // Lowest eligible at or above the pointer wins; otherwise wrap to lowest overall.
  always_comb begin
    hi_id    = '0;
    lo_id    = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    ptr_ext  = 32'(ptr_i);
    for (int k = NUM - 1; k >= 0; k--) begin
      if (eligible_i[k]) begin
        lo_id    = ID_W'(k);
        lo_found = 1'b1;
        if (32'(k) >= ptr_ext) begin
          hi_id    = ID_W'(k);
          hi_found = 1'b1;
        end
      end
    end
    win_id_o = hi_found ? hi_id : lo_id;
    found_o  = lo_found;
  end
`else
  always_comb begin
    win_id_o = '0;
    found_o  = 1'b0;
    for (int k = NUM - 1; k >= 0; k--) begin
      if (eligible_i[k]) begin
        win_id_o = ID_W'(k);
        found_o  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/pms_ext_irq_ctrl.sv
// External interrupt collector: sync, level/edge pending, in-service tracking and
// valid/ready presentation with EOI. PMS_EXT_IRQ_RR_EN selects round-robin priority.
module pms_ext_irq_ctrl
  import pms_top_pkg::*;
#(
  parameter int unsigned NUM_EXT_IRQ = NUM_EXT_IRQ_PMS,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ID_W        = id_width(NUM_EXT_IRQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_EXT_IRQ-1:0] irq_i,
  input  logic [NUM_EXT_IRQ-1:0] enable_i,
  input  logic [NUM_EXT_IRQ-1:0] mode_i,
  output logic                   irq_valid_o,
  output logic [ID_W-1:0]        irq_id_o,
  input  logic                   irq_ready_i,
  input  logic                   eoi_valid_i,
  input  logic [ID_W-1:0]        eoi_id_i,
  output logic [NUM_EXT_IRQ-1:0] pending_o,
  output logic                   busy_o
);

  typedef enum logic {ST_IDLE, ST_PRESENT} state_e;

  logic [SYNC_STAGES-1:0][NUM_EXT_IRQ-1:0] sync_q;
  logic [NUM_EXT_IRQ-1:0] sync, prev_q;
  logic [NUM_EXT_IRQ-1:0] pend_q, pend_d, insvc_q, insvc_d;
  logic [NUM_EXT_IRQ-1:0] hs_vec, eoi_vec, eligible;
  logic                   hs, found;
  logic [ID_W-1:0]        win_id;
  state_e                 state_q;
  logic                   valid_q, busy_q;
  logic [ID_W-1:0]        id_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
      prev_q <= sync;
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];
  assign hs   = valid_q & irq_ready_i;

  always_comb begin
    hs_vec  = '0;
    eoi_vec = '0;
    if (hs) hs_vec[id_q] = 1'b1;
    if (eoi_valid_i && (32'(eoi_id_i) < NUM_EXT_IRQ)) eoi_vec[eoi_id_i] = 1'b1;
  end

  // Edge lines: a fresh edge in the accept cycle outranks the handshake clear.
  always_comb begin
    pend_d = '0;
    for (int k = 0; k < NUM_EXT_IRQ; k++) begin
      if (irq_mode_e'(mode_i[k]) == IRQ_EDGE)
        pend_d[k] = (sync[k] & ~prev_q[k] & enable_i[k]) | (pend_q[k] & ~hs_vec[k]);
      else
        pend_d[k] = sync[k] & enable_i[k];
    end
  end

  // Handshake set is applied after EOI clear so it wins on a same-ID collision.
  assign insvc_d  = (insvc_q & ~eoi_vec) | hs_vec;
  assign eligible = pend_q & enable_i & ~insvc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q  <= '0;
      insvc_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      insvc_q <= insvc_d;
      busy_q  <= |insvc_d;
    end
  end

`ifdef PMS_EXT_IRQ_RR_EN
  logic [ID_W-1:0] ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (hs) begin
      ptr_q <= (32'(id_q) == NUM_EXT_IRQ - 1) ? '0 : id_q + 1'b1;
    end
  end

  pms_irq_prio_arb #(
    .NUM  (NUM_EXT_IRQ),
    .ID_W (ID_W)
  ) u_arb (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .win_id_o   (win_id),
    .found_o    (found)
  );
`else
  pms_irq_prio_arb #(
    .NUM  (NUM_EXT_IRQ),
    .ID_W (ID_W)
  ) u_arb (
    .eligible_i (eligible),
    .win_id_o   (win_id),
    .found_o    (found)
  );
`endif

  // Once presented, the ID is never retracted; only the handshake ends PRESENT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      id_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (found) begin
            id_q    <= win_id;
            valid_q <= 1'b1;
            state_q <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (irq_ready_i) begin
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign irq_valid_o = valid_q;
  assign irq_id_o    = id_q;
  assign pending_o   = pend_q;
  assign busy_o      = busy_q;

endmodule
